mem_access_unit: RTL
====================

# mem_access_unit

Parametrised memory access unit for the multi-cycle MIPS32 core; it sits between the control FSM / datapath registers and external memory. It replaces the single-cycle MemRead/MemWrite strobes and the shared tristate data bus with separate read and write buses and a ready handshake, so memory may insert any number of wait states. It also adds byte-, halfword- and word-sized accesses with byte enables, load sign/zero extension, alignment checking, and an optional bus timeout.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, memory data width. Legal values: 32 or 64.
- TIMEOUT, 255, maximum number of wait cycles in ACCESS before a bus error. Used only with MAU_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  asynchronous reset, active-high (1 = reset).
- req  in  1  access request from the control FSM; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W = 64).
- sign_ext  in  1  loads only: 1 = sign-extend the result, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  store data, right-aligned (the B register value).
- rdata  out  DATA_W  extended load result, right-aligned; held until the next load completes.
- busy  out  1  1 whenever state ≠ IDLE; stalls the control FSM.
- done  out  1  one-cycle completion pulse.
- err  out  1  asserted together with done when the access failed.
- err_cause  out  2  0 = none, 1 = misaligned, 2 = timeout; held until the next accepted req.
- mem_addr  out  ADDR_W  addr with its low log2(DATA_W/8) bits cleared.
- mem_rd  out  1  read strobe; held until mem_ready.
- mem_wr  out  1  write strobe; held until mem_ready.
- mem_be  out  DATA_W/8  byte enables.
- mem_wdata  out  DATA_W  store data replicated across all byte lanes.
- mem_rdata  in  DATA_W  read data; valid in the cycle where mem_ready = 1.
- mem_ready  in  1  completion from memory.

## Operation
The block has three states: IDLE, ACCESS and RESP.

**IDLE**
- When req = 1, latch we, size, sign_ext, addr and wdata.
- Let off = addr[log2(DATA_W/8)-1:0]. The access is misaligned when off is not a multiple of the access size in bytes (1, 2, 4 or 8). A size of 3 with DATA_W = 32 is also treated as misaligned.
- Misaligned: go to RESP with err = 1 and err_cause = 1. No bus strobe is issued.
- Aligned: go to ACCESS and set err_cause = 0.

**ACCESS**
- mem_rd = ~we and mem_wr = we. mem_be has (2^size) ones starting at bit off.
- The remaining bus outputs stay constant for the whole state.
- When mem_ready = 1:
  - On a load, shift mem_rdata right by off*8, keep the low 8 × 2^size bits, extend them according to sign_ext, and write the result to rdata.
  - Then go to RESP.

**RESP**
- done = 1 for exactly one cycle, then return to IDLE.
- req is ignored in ACCESS and RESP. It is never queued.
- Stores and failed accesses leave rdata unchanged.

**Reset**
- Asserting nrst at any time forces IDLE.
- All outputs return to 0: rdata, err_cause, mem_addr, mem_be, mem_wdata and every strobe.
- An in-flight bus cycle is abandoned immediately; the strobes drop asynchronously.

## Timing
- Request accepted at edge E0. mem_rd or mem_wr is high from E0 until the edge at which mem_ready is sampled high.
- Zero-wait memory (mem_ready = 1 in the first ACCESS cycle): done is high in the cycle after E1, and busy is low after E2. The minimum request-to-done latency is 2 cycles.
- Each cycle with mem_ready = 0 adds one cycle of latency.
- Misaligned request: done = err = 1 in the cycle after E0.
- mem_ready is ignored outside ACCESS.
- The bus outputs are registered; none of them depends combinationally on req.

## Configuration
MAU_TIMEOUT_EN controls the bus timeout.
- **Defined:** a wait counter clears on entry to ACCESS and increments every ACCESS cycle with mem_ready = 0. When it reaches TIMEOUT, the strobes drop, the block goes to RESP with err = 1 and err_cause = 2, and rdata is unchanged. If mem_ready is high in the same cycle the count is reached, mem_ready wins and the access completes normally.
- **Undefined:** there is no counter. ACCESS waits for mem_ready indefinitely, and err_cause never takes the value 2.

## Test plan
- **Word load, no wait states.** DATA_W = 32, addr = 0x100, mem_rdata = 0xDEADBEEF, mem_ready tied to 1 → mem_rd for 1 cycle, mem_be = 4'hF, done 2 cycles after req, rdata = 0xDEADBEEF.
- **Byte loads with extension.** addr = 0x103, mem_rdata = 0x80FFFFFF → mem_be = 4'h8. With sign_ext = 1, rdata = 0xFFFFFF80. With sign_ext = 0, rdata = 0x00000080.
- **Halfword store with wait states.** addr = 0x202, wdata = 0x1234, 3 wait cycles → mem_be = 4'hC, mem_wdata = 0x12341234, mem_wr held for 4 cycles, done 1 cycle after mem_ready, rdata unchanged.
- **Misaligned access.** Word load at addr = 0x101 → no strobe, done = err = 1 in the next cycle, err_cause = 1.
- **Timeout (MAU_TIMEOUT_EN defined).** TIMEOUT = 4, mem_ready held at 0 → strobe drops after 4 ACCESS cycles, err = 1, err_cause = 2. With the macro undefined, busy stays at 1 for more than 100 cycles.
- **Reset mid-access and extra requests.** Assert nrst during ACCESS → mem_rd falls immediately and all outputs read 0. Pulse req again while busy → it is ignored, and only one done pulse is produced.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Memory-side bus of mem_access_unit: registered strobes/address/data out,
// read data and ready handshake back from memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rd;
  logic                mem_wr;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_be, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_be, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// Sized load/store unit with ready handshake, alignment check and extension.
// Define MAU_TIMEOUT_EN to add a bus timeout of TIMEOUT wait cycles.

// One byte lane: enable bit and replicated store byte for lane LANE.
module mau_lane #(
  parameter int DATA_W = 32,
  parameter int LANE   = 0,
  parameter int OFF_W  = 2
) (
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] wdata,
  output logic              be,
  output logic [7:0]        wbyte
);
  localparam int NB = DATA_W / 8;

  logic [4:0]            nb, lo;
  logic [OFF_W-1:0]      idx;
  logic [NB-1:0][7:0]    wl;

  assign nb  = 5'd1 << size;
  assign lo  = 5'(off);
  assign be  = (5'(LANE) >= lo) && (5'(LANE) < lo + nb);
  // store data is right-aligned, so lane picks byte (LANE mod access bytes)
  assign idx = OFF_W'(5'(LANE) & (nb - 5'd1));
  assign wl  = wdata;
  assign wbyte = wl[idx];
endmodule

module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_cause,
  mem_access_unit_if.master bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic             we;
    logic [1:0]       size;
    logic             sign_ext;
    logic [OFF_W-1:0] off;
  } req_t;

  state_t               state, state_nxt;
  req_t                 rq;
  logic                 err_q;
  logic [OFF_W-1:0]     off;
  logic                 misaligned;
  logic                 tmo;
  logic [NB-1:0]        be_nxt;
  logic [NB-1:0][7:0]   wdata_nxt;
  logic [DATA_W-1:0]    sh, ld_ext;
  logic                 msb;
  int                   nbits;

  assign off = addr[OFF_W-1:0];

  always_comb begin
    misaligned = |(4'(off) & ((4'd1 << size) - 4'd1));
    if (size == 2'd3 && DATA_W == 32) misaligned = 1'b1;
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    mau_lane #(.DATA_W(DATA_W), .LANE(i), .OFF_W(OFF_W)) u_lane (
      .off   (off),
      .size  (size),
      .wdata (wdata),
      .be    (be_nxt[i]),
      .wbyte (wdata_nxt[i])
    );
  end

`ifdef MAU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wcnt;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst)                  wcnt <= '0;
    else if (state != ACCESS)  wcnt <= '0;
    else if (!bus.mem_ready)   wcnt <= wcnt + 1'b1;
  end

  // ready in the same cycle as the final count still completes normally
  assign tmo = (state == ACCESS) && !bus.mem_ready && (wcnt == CNT_W'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  // load extraction: align the addressed bytes down, then extend
  always_comb begin
    sh = bus.mem_rdata >> {rq.off, 3'b000};
    case (rq.size)
      2'd0:    begin nbits = 8;      msb = sh[7];        end
      2'd1:    begin nbits = 16;     msb = sh[15];       end
      2'd2:    begin nbits = 32;     msb = sh[31];       end
      default: begin nbits = DATA_W; msb = sh[DATA_W-1]; end
    endcase
    for (int i = 0; i < DATA_W; i++)
      ld_ext[i] = (i < nbits) ? sh[i] : (rq.sign_ext & msb);
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = misaligned ? RESP : ACCESS;
      ACCESS:  if (bus.mem_ready || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == RESP);
    err  = (state == RESP) && err_q;
  end

  // bus outputs and result registers
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      rq            <= '0;
      err_q         <= 1'b0;
      err_cause     <= 2'd0;
      rdata         <= '0;
      bus.mem_addr  <= '0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          rq        <= req_t'({we, size, sign_ext, off});
          err_q     <= misaligned;
          err_cause <= misaligned ? 2'd1 : 2'd0;
          if (!misaligned) begin
            bus.mem_addr  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus.mem_be    <= be_nxt;
            bus.mem_wdata <= wdata_nxt;
            bus.mem_rd    <= !we;
            bus.mem_wr    <= we;
          end
        end
        ACCESS: if (bus.mem_ready || tmo) begin
          bus.mem_rd <= 1'b0;
          bus.mem_wr <= 1'b0;
          if (bus.mem_ready) begin
            if (!rq.we) rdata <= ld_ext;
          end else begin
            err_q     <= 1'b1;
            err_cause <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
